// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: merges cache freezes, load-use bubbles
// and EX mispredict redirects into per-stage controls, with saturating performance counters.
module pipeline_hazard_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_icache_stall,
    input  logic             i_dcache_stall,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic             i_ex_memread,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mispredict,
    input  logic [XLEN-1:0]  i_ex_target,
    output logic             o_pipe_stall,
    output logic             o_pc_hold,
    output logic             o_ifid_hold,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_idex_flush,
    output logic             o_pc_redirect,
    output logic [XLEN-1:0]  o_pc_redirect_target,
    output logic [CNT_W-1:0] o_perf_stall_cnt,
    output logic [CNT_W-1:0] o_perf_bubble_cnt,
    output logic [CNT_W-1:0] o_perf_flush_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [XLEN-1:0]  r_pend_tgt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_stall;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_load_use;
    logic             w_capture;
    logic             w_pipe_stall;
    logic             w_pc_hold;
    logic             w_ifid_hold;
    logic             w_ifid_flush;
    logic             w_idex_bubble;
    logic             w_idex_flush;
    logic             w_pc_redirect;
    logic [XLEN-1:0]  w_redirect_target;

    assign w_stall    = i_icache_stall | i_dcache_stall;
    assign w_rs1_hit  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    assign w_load_use = i_ex_memread && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_pend_tgt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_pend_tgt <= i_ex_target;
            end
        end
    end

    // Priority: reset > freeze > redirect (pending or live) > load-use bubble.
    always_comb begin
        w_next_state      = r_state;
        w_capture         = 1'b0;
        w_pipe_stall      = 1'b0;
        w_pc_hold         = 1'b0;
        w_ifid_hold       = 1'b0;
        w_ifid_flush      = 1'b0;
        w_idex_bubble     = 1'b0;
        w_idex_flush      = 1'b0;
        w_pc_redirect     = 1'b0;
        w_redirect_target = '0;
        if (rst_n) begin
            case (r_state)
                ST_RUN: begin
                    if (w_stall) begin
                        w_pipe_stall = 1'b1;
                        w_pc_hold    = 1'b1;
                        w_ifid_hold  = 1'b1;
                        if (i_ex_mispredict) begin
                            w_capture    = 1'b1;
                            w_next_state = ST_PEND;
                        end
                    end else if (i_ex_mispredict) begin
                        w_pc_redirect     = 1'b1;
                        w_redirect_target = i_ex_target;
                        w_ifid_flush      = 1'b1;
                        w_idex_flush      = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_hold     = 1'b1;
                        w_ifid_hold   = 1'b1;
                        w_idex_bubble = 1'b1;
                    end
                end
                ST_PEND: begin
                    // EX is frozen here, so a new mispredict is stale; the captured one wins.
                    if (w_stall) begin
                        w_pipe_stall = 1'b1;
                        w_pc_hold    = 1'b1;
                        w_ifid_hold  = 1'b1;
                    end else begin
                        w_pc_redirect     = 1'b1;
                        w_redirect_target = r_pend_tgt;
                        w_ifid_flush      = 1'b1;
                        w_idex_flush      = 1'b1;
                        w_next_state      = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_pipe_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_idex_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
            if (w_pc_redirect && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pipe_stall         = w_pipe_stall;
    assign o_pc_hold            = w_pc_hold;
    assign o_ifid_hold          = w_ifid_hold;
    assign o_ifid_flush         = w_ifid_flush;
    assign o_idex_bubble        = w_idex_bubble;
    assign o_idex_flush         = w_idex_flush;
    assign o_pc_redirect        = w_pc_redirect;
    assign o_pc_redirect_target = w_redirect_target;
    assign o_perf_stall_cnt     = rst_n ? r_stall_cnt  : '0;
    assign o_perf_bubble_cnt    = rst_n ? r_bubble_cnt : '0;
    assign o_perf_flush_cnt     = rst_n ? r_flush_cnt  : '0;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic, checked against a
// rule-level reference model; a second instance with 4-bit counters exercises saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icStall, dcStall;
    logic [4:0]  idRs1, idRs2, exRd;
    logic        useRs1, useRs2, exMemread, exMis;
    logic [31:0] exTarget;

    logic        pipeStall, pcHold, ifidHold, ifidFlush, idexBubble, idexFlush, pcRedirect;
    logic [31:0] redirectTarget;
    logic [31:0] stallCnt, bubbleCnt, flushCnt;
    logic        pipeStall4, pcHold4, ifidHold4, ifidFlush4, idexBubble4, idexFlush4, pcRedirect4;
    logic [31:0] redirectTarget4;
    logic [3:0]  stallCnt4, bubbleCnt4, flushCnt4;

    int testsRun = 0;
    int failCount = 0;

    // Reference model state: pending redirect flag/target and unbounded event counts.
    bit          mPend;
    logic [31:0] mTgt;
    longint      mStalls, mBubbles, mFlushes;
    logic        eStall, eHold, eBubble, eRedirect;
    logic [31:0] eTarget;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_icache_stall(icStall), .i_dcache_stall(dcStall),
        .i_id_rs1(idRs1), .i_id_rs2(idRs2), .i_id_use_rs1(useRs1), .i_id_use_rs2(useRs2),
        .i_ex_memread(exMemread), .i_ex_rd(exRd), .i_ex_mispredict(exMis), .i_ex_target(exTarget),
        .o_pipe_stall(pipeStall), .o_pc_hold(pcHold), .o_ifid_hold(ifidHold),
        .o_ifid_flush(ifidFlush), .o_idex_bubble(idexBubble), .o_idex_flush(idexFlush),
        .o_pc_redirect(pcRedirect), .o_pc_redirect_target(redirectTarget),
        .o_perf_stall_cnt(stallCnt), .o_perf_bubble_cnt(bubbleCnt), .o_perf_flush_cnt(flushCnt)
    );

    pipeline_hazard_ctrl #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_icache_stall(icStall), .i_dcache_stall(dcStall),
        .i_id_rs1(idRs1), .i_id_rs2(idRs2), .i_id_use_rs1(useRs1), .i_id_use_rs2(useRs2),
        .i_ex_memread(exMemread), .i_ex_rd(exRd), .i_ex_mispredict(exMis), .i_ex_target(exTarget),
        .o_pipe_stall(pipeStall4), .o_pc_hold(pcHold4), .o_ifid_hold(ifidHold4),
        .o_ifid_flush(ifidFlush4), .o_idex_bubble(idexBubble4), .o_idex_flush(idexFlush4),
        .o_pc_redirect(pcRedirect4), .o_pc_redirect_target(redirectTarget4),
        .o_perf_stall_cnt(stallCnt4), .o_perf_bubble_cnt(bubbleCnt4), .o_perf_flush_cnt(flushCnt4)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] sat(input longint count, input int width);
        longint maxVal;
        maxVal = (longint'(1) << width) - 1;
        return (count > maxVal) ? 64'(maxVal) : 64'(count);
    endfunction

    // Expected outputs follow the priority reset > freeze > redirect > load-use.
    task automatic checkOutput();
        logic loadUse;
        loadUse = exMemread && (exRd != 0) &&
                  ((useRs1 && idRs1 == exRd) || (useRs2 && idRs2 == exRd));
        eStall = 0; eHold = 0; eBubble = 0; eRedirect = 0; eTarget = 0;
        if (rst_n) begin
            if (icStall || dcStall) begin
                eStall = 1; eHold = 1;
            end else if (mPend) begin
                eRedirect = 1; eTarget = mTgt;
            end else if (exMis) begin
                eRedirect = 1; eTarget = exTarget;
            end else if (loadUse) begin
                eHold = 1; eBubble = 1;
            end
        end
        check("pipe_stall",   64'(pipeStall),      64'(eStall));
        check("pc_hold",      64'(pcHold),         64'(eHold));
        check("ifid_hold",    64'(ifidHold),       64'(eHold));
        check("ifid_flush",   64'(ifidFlush),      64'(eRedirect));
        check("idex_bubble",  64'(idexBubble),     64'(eBubble));
        check("idex_flush",   64'(idexFlush),      64'(eRedirect));
        check("pc_redirect",  64'(pcRedirect),     64'(eRedirect));
        check("redirect_tgt", 64'(redirectTarget), 64'(eTarget));
        check("stall_cnt",    64'(stallCnt),       rst_n ? sat(mStalls, 32)  : 64'd0);
        check("bubble_cnt",   64'(bubbleCnt),      rst_n ? sat(mBubbles, 32) : 64'd0);
        check("flush_cnt",    64'(flushCnt),       rst_n ? sat(mFlushes, 32) : 64'd0);
        check("w4_redirect",  64'(pcRedirect4),    64'(eRedirect));
        check("w4_bubble",    64'(idexBubble4),    64'(eBubble));
        check("w4_stall_cnt", 64'(stallCnt4),      rst_n ? sat(mStalls, 4)   : 64'd0);
        check("w4_bubble_cnt",64'(bubbleCnt4),     rst_n ? sat(mBubbles, 4)  : 64'd0);
        check("w4_flush_cnt", 64'(flushCnt4),      rst_n ? sat(mFlushes, 4)  : 64'd0);
    endtask

    task automatic applyStimulus(input logic r, input logic ic, input logic dc,
                                 input logic [4:0] a1, input logic [4:0] a2,
                                 input logic u1, input logic u2, input logic mr,
                                 input logic [4:0] rd, input logic mis, input logic [31:0] tgt);
        @(negedge clk);
        rst_n = r; icStall = ic; dcStall = dc; idRs1 = a1; idRs2 = a2;
        useRs1 = u1; useRs2 = u2; exMemread = mr; exRd = rd; exMis = mis; exTarget = tgt;
        #1;
        checkOutput();
        @(posedge clk);
        if (!r) begin
            mPend = 0; mTgt = 0; mStalls = 0; mBubbles = 0; mFlushes = 0;
        end else begin
            if (eStall) begin
                mStalls++;
                if (!mPend && mis) begin
                    mPend = 1; mTgt = tgt;
                end
            end else if (mPend) begin
                mPend = 0;
            end
            if (eBubble)   mBubbles++;
            if (eRedirect) mFlushes++;
        end
        #1;
    endtask

    task automatic idle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic        prevMis;
        logic        rr, ic, dc, u1, u2, mr, mis;
        logic [4:0]  a1, a2, rd;
        mPend = 0; mTgt = 0; mStalls = 0; mBubbles = 0; mFlushes = 0;
        rst_n = 0; icStall = 0; dcStall = 0; idRs1 = 0; idRs2 = 0;
        useRs1 = 0; useRs2 = 0; exMemread = 0; exRd = 0; exMis = 0; exTarget = 0;

        doReset();

        // Scenario 1: load-use on rs1 gives exactly one bubble.
        applyStimulus(1, 0, 0, 5, 0, 1, 0, 1, 5, 0, 0);
        idle();
        check("t1_bubble_cnt", 64'(bubbleCnt), 64'd1);
        check("t1_no_repeat", 64'(idexBubble), 64'd0);

        // Scenario 2: load to x0 never stalls decode.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        idle();
        check("t2_bubble_cnt", 64'(bubbleCnt), 64'd0);

        // Scenario 3: live mispredict redirects in the same cycle.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100);
        check("t3_flush_cnt", 64'(flushCnt), 64'd1);

        // Scenario 4: mispredict captured during a 3-cycle freeze, replayed on release.
        doReset();
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h200);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h999);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_stall_cnt", 64'(stallCnt), 64'd3);
        check("t4_flush_cnt", 64'(flushCnt), 64'd1);

        // Scenario 5: redirect beats a simultaneous load-use.
        doReset();
        applyStimulus(1, 0, 0, 0, 7, 0, 1, 1, 7, 1, 32'h300);
        check("t5_bubble_cnt", 64'(bubbleCnt), 64'd0);
        check("t5_flush_cnt", 64'(flushCnt), 64'd1);

        // Scenario 6: reset while pending drops the redirect; then 4-bit saturation.
        doReset();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400);
        doReset();
        idle();
        check("t6_no_redirect_flush", 64'(flushCnt), 64'd0);
        for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_stall_cnt4", 64'(stallCnt4), 64'd15);
        check("t6_stall_cnt32", 64'(stallCnt), 64'd20);

        // Random traffic with a small register range to provoke hazards often.
        doReset();
        prevMis = 0;
        for (int i = 0; i < 600; i++) begin
            rr  = ($urandom_range(0, 59) != 0);
            ic  = ($urandom_range(0, 5) == 0);
            dc  = ($urandom_range(0, 4) == 0);
            a1  = 5'($urandom_range(0, 3));
            a2  = 5'($urandom_range(0, 3));
            u1  = 1'($urandom);
            u2  = 1'($urandom);
            mr  = 1'($urandom);
            rd  = 5'($urandom_range(0, 3));
            mis = !prevMis && ($urandom_range(0, 4) == 0);
            prevMis = mis;
            applyStimulus(rr, ic, dc, a1, a2, u1, u2, mr, rd, mis, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
